// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Multi-cycle control sequencer for the 2-bit datapath ALU. Holds a small
// instruction buffer and a four-entry 2-bit register file. On start it steps
// through the program from address 0. Each instruction takes three states:
// FETCH, EXEC and WB. The ALU is driven combinationally during EXEC, its
// 8-bit result is latched on the EXEC->WB edge, and the low 2 bits are
// written back to R[dst] in WB.
//
// Instruction word: {opcode[9:6], dst[5:4], srcA[3:2], srcB[1:0]}
//
// Optional feature macro: ALU_SEQ_STEP_EN
//   When defined, this adds a `step` input and a PAUSE state after every WB.
//   The sequencer holds in PAUSE until step=1, then takes the transition
//   that WB would otherwise have taken.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           begin a run (sampled in IDLE only)
//   prog_len        instruction count, clamped to PROG_DEPTH
//   prog_we/addr/wdata  program buffer write (ignored while busy)
//   reg_we/addr/wdata   register preload (ignored while busy)
//   step            single-step advance (ALU_SEQ_STEP_EN only)
//   alu_a/b/opcode  ALU drive, zero outside EXEC
//   alu_out         combinational ALU result
//   result          last latched ALU result
//   result_valid    pulse in WB
//   busy            high outside IDLE
//   done            pulse in DONE
//   pc              current instruction address
//   reg_rdata       {R3,R2,R1,R0}
module alu_sequencer #(
    parameter int PROG_DEPTH = 8,
    parameter int AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [9:0]    prog_wdata,
    input  logic          reg_we,
    input  logic [1:0]    reg_addr,
    input  logic [1:0]    reg_wdata,
`ifdef ALU_SEQ_STEP_EN
    input  logic          step,
`endif
    output logic [1:0]    alu_a,
    output logic [1:0]    alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [7:0]    alu_out,
    output logic [7:0]    result,
    output logic          result_valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [7:0]    reg_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_DONE
`ifdef ALU_SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(PROG_DEPTH);

    state_t        state_q, state_d;
    logic [9:0]    mem [PROG_DEPTH];
    logic [9:0]    ir;
    logic [AW:0]   len_q;
    logic [1:0]    rf [4];
    logic          last;
    logic          pc_adv;

    // The final instruction is the one at address len_q-1; pc never wraps.
    assign last = ({1'b0, pc} == (len_q - (AW+1)'(1)));

    always_comb begin
        state_d = state_q;
        pc_adv  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (prog_len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
`ifdef ALU_SEQ_STEP_EN
            S_WB:    state_d = S_PAUSE;
            S_PAUSE: begin
                if (step) begin
                    state_d = last ? S_DONE : S_FETCH;
                    pc_adv  = !last;
                end
            end
`else
            S_WB: begin
                state_d = last ? S_DONE : S_FETCH;
                pc_adv  = !last;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign result_valid = (state_q == S_WB);
    assign alu_a        = (state_q == S_EXEC) ? rf[ir[3:2]] : 2'b00;
    assign alu_b        = (state_q == S_EXEC) ? rf[ir[1:0]] : 2'b00;
    assign alu_opcode   = (state_q == S_EXEC) ? ir[9:6]     : 4'h0;
    assign reg_rdata    = {rf[3], rf[2], rf[1], rf[0]};

    // Program buffer keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc      <= '0;
            len_q   <= '0;
            ir      <= '0;
            result  <= '0;
            rf      <= '{default: 2'b00};
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start && prog_len != '0) begin
                len_q <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                pc    <= '0;
            end
            if (pc_adv) pc <= pc + AW'(1);
            // A same-cycle prog_we with start lands before this read.
            if (state_q == S_FETCH) ir <= mem[pc];
            if (state_q == S_EXEC) result <= alu_out;
            // Preloads are only honoured in IDLE, WB is always busy, so the
            // two register-file writers never collide.
            if (reg_we && !busy) rf[reg_addr] <= reg_wdata;
            if (state_q == S_WB) rf[ir[5:4]] <= result[1:0];
        end
    end

endmodule
